// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver with prefix stripping.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] message_out,
  output logic       message_latch,
  output logic       release_key,
  output logic       extended_code,
  output logic       frame_error,
  output logic       parity_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          filt, filt_q;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0]    bcnt;
  logic [7:0]    shift;
  logic          fall;
  logic          par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // The filtered clock only follows a level held for FILTER_LEN samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt   <= 1'b1;
      filt_q <= 1'b1;
      fcnt   <= '0;
    end else begin
      filt_q <= filt;
      if (clk_s2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= clk_s2;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign fall = filt_q & ~filt;

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;

  assign par_bad = ~(^{shift, par_bit});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit      <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      parity_error <= 1'b0;
      if (state == PARITY && fall)
        par_bit <= dat_s2;
      if (state == STOP && fall && dat_s2 && par_bad)
        parity_error <= 1'b1;
    end
  end
`else
  assign par_bad      = 1'b0;
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tcnt          <= '0;
      bcnt          <= '0;
      shift         <= '0;
      message_out   <= '0;
      message_latch <= 1'b0;
      release_key   <= 1'b0;
      extended_code <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      message_latch <= 1'b0;
      release_key   <= 1'b0;
      extended_code <= 1'b0;
      frame_error   <= 1'b0;

      // A fall in the same cycle as the timeout wins.
      if (state == IDLE || fall) begin
        tcnt <= '0;
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        tcnt        <= '0;
        state       <= IDLE;
        frame_error <= 1'b1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end

      if (fall) begin
        unique case (state)
          IDLE: begin
            if (!dat_s2) begin
              state <= DATA;
              bcnt  <= '0;
              shift <= '0;
            end
          end
          DATA: begin
            shift <= {dat_s2, shift[7:1]};
            bcnt  <= bcnt + 1'b1;
            if (bcnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!dat_s2) begin
              frame_error <= 1'b1;
            end else if (par_bad) begin
              message_latch <= 1'b0;
            end else if (shift == 8'hF0) begin
              release_key <= 1'b1;
            end else if (shift == 8'hE0) begin
              extended_code <= 1'b1;
            end else begin
              message_out   <= shift;
              message_latch <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: scoreboard of expected pulses
// pushed per frame and compared when the DUT pulses.
module tb_ps2_receiver;

  localparam int FL   = 8;
  localparam int TO   = 1000;
  localparam int HALF = 40;

  localparam logic [4:0] LAT = 5'b00001;
  localparam logic [4:0] REL = 5'b00010;
  localparam logic [4:0] EXT = 5'b00100;
  localparam logic [4:0] FER = 5'b01000;
  localparam logic [4:0] PER = 5'b10000;

  typedef struct {
    logic [4:0] p;
    logic [7:0] m;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] message_out;
  logic       message_latch;
  logic       release_key;
  logic       extended_code;
  logic       frame_error;
  logic       parity_error;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         ev_cyc = 0;
  int         fall_cyc = 0;
  logic [7:0] last_msg = 8'h00;
  ev_t        expq[$];

  ps2_receiver #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .message_out  (message_out),
    .message_latch(message_latch),
    .release_key  (release_key),
    .extended_code(extended_code),
    .frame_error  (frame_error),
    .parity_error (parity_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every pulse cycle pops and compares one expected event.
  always @(negedge clk) begin
    logic [4:0] pv;
    ev_t e;
    pv = {parity_error, frame_error, extended_code,
          release_key, message_latch};
    if (pv != 5'b0) begin
      tests++;
      ev_cyc = cyc;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got pulses=%b msg=%h, required none",
                 pv, message_out);
      end else begin
        e = expq.pop_front();
        if (pv !== e.p || message_out !== e.m) begin
          fails++;
          $display("FAIL pulse: got pulses=%b msg=%h, required pulses=%b msg=%h",
                   pv, message_out, e.p, e.m);
        end
      end
    end
  end

  task automatic push_exp(input logic [4:0] p, input logic [7:0] b);
    ev_t e;
    if (p == LAT)
      last_msg = b;
    e.p = p;
    e.m = last_msg;
    expq.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++)
      send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (30) @(posedge clk);
  endtask

  task automatic end_check(input string name);
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL %s_missing: got %0d events pending, required 0",
               name, expq.size());
    end
    expq.delete();
    tests++;
    if (message_out !== last_msg) begin
      fails++;
      $display("FAIL %s_msg_hold: got %h, required %h",
               name, message_out, last_msg);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    tests++;
    if ({message_out, message_latch, release_key, extended_code,
         frame_error, parity_error} !== 13'b0) begin
      fails++;
      $display("FAIL reset_outputs: got msg=%h pulses=%b, required all 0",
               message_out, {parity_error, frame_error, extended_code,
                             release_key, message_latch});
    end
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_single;
    push_exp(LAT, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0);
    end_check("single");
  endtask

  task automatic test_release;
    push_exp(LAT, 8'h33);
    send_frame(8'h33, 1'b0, 1'b0);
    push_exp(REL, 8'hF0);
    push_exp(LAT, 8'h1C);
    send_frame(8'hF0, 1'b0, 1'b0);
    tests++;
    if (message_out !== 8'h33) begin
      fails++;
      $display("FAIL release_hold: got %h, required 33", message_out);
    end
    send_frame(8'h1C, 1'b0, 1'b0);
    end_check("release");
  endtask

  task automatic test_extended;
    push_exp(EXT, 8'hE0);
    push_exp(REL, 8'hF0);
    push_exp(LAT, 8'h75);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    end_check("extended");
  endtask

  task automatic test_parity;
`ifdef PS2_PARITY_CHECK_EN
    push_exp(PER, 8'h1C);
`else
    push_exp(LAT, 8'h1C);
`endif
    send_frame(8'h1C, 1'b1, 1'b0);
    end_check("parity");
  endtask

  task automatic test_stop_error;
    push_exp(FER, 8'h00);
    send_frame(8'h5A, 1'b0, 1'b1);
    push_exp(LAT, 8'h32);
    send_frame(8'h32, 1'b0, 1'b0);
    end_check("stop_error");
  endtask

  task automatic test_timeout;
    int d;
    push_exp(FER, 8'h00);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++)
      send_bit(1'b1);
    for (int i = 0; i < TO + 300 && expq.size() > 0; i++)
      @(posedge clk);
    d = ev_cyc - fall_cyc;
    tests++;
    if (expq.size() != 0 || d < TO + FL || d > TO + FL + 8) begin
      fails++;
      $display("FAIL timeout_delay: got %0d cycles (pending %0d), required %0d..%0d",
               d, expq.size(), TO + FL, TO + FL + 8);
    end
    push_exp(LAT, 8'h2B);
    send_frame(8'h2B, 1'b0, 1'b0);
    end_check("timeout");
  endtask

  task automatic test_mid_reset;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++)
      send_bit(1'b1);
    ps2_clk = 1'b0;
    repeat (15) @(posedge clk);
    rst_n = 1'b0;
    last_msg = 8'h00;
    repeat (5) @(posedge clk);
    tests++;
    if ({message_out, message_latch, release_key, extended_code,
         frame_error, parity_error} !== 13'b0) begin
      fails++;
      $display("FAIL midreset_outputs: got msg=%h, required 00 and no pulses",
               message_out);
    end
    ps2_clk = 1'b1;
    repeat (5) @(posedge clk);
    rst_n = 1'b1;
    repeat (TO + 100) @(posedge clk);
    push_exp(LAT, 8'h15);
    send_frame(8'h15, 1'b0, 1'b0);
    end_check("midreset");
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(1, 8'hDF));
      push_exp(LAT, b);
      send_frame(b, 1'b0, 1'b0);
    end
    end_check("back_to_back");
  endtask

  initial begin
    test_reset();
    test_single();
    test_release();
    test_extended();
    test_parity();
    test_stop_error();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
